// File: rtl/pipe_comp_pkg.sv
// pipe_comp_pkg: shared definitions for the pipe_comp 5-stage MIPS-subset CPU.
// Contents: opcode/funct codes, ALU operation enum, NOP encoding, the
// pipeline-register struct types, and small helper functions.
package pipe_comp_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  // All-zero value of every stage struct is a bubble (no writes of any kind).
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [4:0]  shamt;
    alu_op_e     alu_op;
    logic        alu_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        br_eq;
    logic        br_ne;
    logic        jmp;
    logic        jmp_reg;
    logic        link;
  } idex_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st_data;
    logic [4:0]  dst;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic        reg_wr;
  } memwb_t;

  function automatic logic [31:0] alu_f(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: r = b << sh;
      ALU_SRL: r = b >> sh;
      default: r = b;
    endcase
    return r;
  endfunction

  // True when a producer writing dst feeds a consumer reading src; $0 never matches.
  function automatic logic raw_hit(input logic wr, input logic [4:0] dst,
                                   input logic [4:0] src, input logic used);
    return wr && used && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_comp_rf.sv
// pipe_comp_rf: 32x32 register file.
// Ports: i_clk/i_rst_n (async active-low clear), read ports i_ra1/i_ra2 ->
// o_rd1/o_rd2 with write-data bypass, write port i_we/i_wa/i_wd,
// debug port i_dbg_sel -> o_dbg_data (plain array read, no bypass).
module pipe_comp_rf
  import pipe_comp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_dbg_sel,
  output logic [31:0] o_dbg_data
);

  logic [31:0] r_regs [0:NUM_REGS-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Bypass lets ID see the value WB is writing this cycle, so WB->ID never stalls.
  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
  assign o_dbg_data = (i_dbg_sel == 5'd0) ? '0 : r_regs[i_dbg_sel];

endmodule

// File: rtl/pipe_comp.sv
// pipe_comp: 5-stage (IF/ID/EX/MEM/WB) MIPS-subset CPU with instruction ROM
// (U_IM.ROM, backdoor loaded, not reset) and a resettable data RAM.
// Ports: clk, rstn (async active-low), reg_sel -> reg_data (debug register read).
// Build option: FORWARD_EN defined enables EX/MEM and MEM/WB forwarding with a
// one-cycle load-use stall; undefined, ID stalls on any RAW against EX or MEM.
module pipe_comp
  import pipe_comp_pkg::*;
#(
  parameter int          IM_DEPTH = 128,
  parameter int          DM_DEPTH = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  idex_t       r_idex;
  exmem_t      r_exmem;
  memwb_t      r_memwb;
  logic [31:0] r_dmem [0:DM_DEPTH-1];

  logic [31:0] w_instr, w_rd1, w_rd2, w_mem_val, w_op_a, w_op_b, w_alu_b, w_ex_res, w_target;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt;
  logic        w_uses_rs, w_uses_rt, w_stall, w_taken;
  idex_t       w_dec;

  if (1) begin : U_IM
    logic [31:0] ROM [0:IM_DEPTH-1];
  end
  assign w_instr = U_IM.ROM[r_pc[IM_AW+1:2]];

  assign w_op = r_ifid.instr[31:26];
  assign w_fn = r_ifid.instr[5:0];
  assign w_rs = r_ifid.instr[25:21];
  assign w_rt = r_ifid.instr[20:16];

  pipe_comp_rf u_rf (
    .i_clk      (clk),
    .i_rst_n    (rstn),
    .i_ra1      (w_rs),
    .i_ra2      (w_rt),
    .o_rd1      (w_rd1),
    .o_rd2      (w_rd2),
    .i_we       (r_memwb.reg_wr),
    .i_wa       (r_memwb.dst),
    .i_wd       (r_memwb.wdata),
    .i_dbg_sel  (reg_sel),
    .o_dbg_data (reg_data)
  );

  // ID: decode; unknown opcodes/functs leave every write enable low.
  always_comb begin
    w_dec       = '0;
    w_dec.pc4   = r_ifid.pc4;
    w_dec.a     = w_rd1;
    w_dec.b     = w_rd2;
    w_dec.imm   = {{16{r_ifid.instr[15]}}, r_ifid.instr[15:0]};
    w_dec.jidx  = r_ifid.instr[25:0];
    w_dec.rs    = w_rs;
    w_dec.rt    = w_rt;
    w_dec.dst   = w_rt;
    w_dec.shamt = r_ifid.instr[10:6];
    w_uses_rs   = 1'b1;
    w_uses_rt   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt    = 1'b1;
        w_dec.dst    = r_ifid.instr[15:11];
        w_dec.reg_wr = 1'b1;
        case (w_fn)
          FN_ADD: w_dec.alu_op = ALU_ADD;
          FN_SUB: w_dec.alu_op = ALU_SUB;
          FN_AND: w_dec.alu_op = ALU_AND;
          FN_OR:  w_dec.alu_op = ALU_OR;
          FN_SLT: w_dec.alu_op = ALU_SLT;
          FN_SLL: w_dec.alu_op = ALU_SLL;
          FN_SRL: w_dec.alu_op = ALU_SRL;
          FN_JR: begin
            w_dec.reg_wr  = 1'b0;
            w_dec.jmp_reg = 1'b1;
            w_uses_rt     = 1'b0;
          end
          default: w_dec.reg_wr = 1'b0;
        endcase
      end
      OP_ADDI: begin w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; end
      OP_SLTI: begin w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_SLT; end
      OP_ANDI: begin
        w_dec.imm = {16'b0, r_ifid.instr[15:0]};
        w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_AND;
      end
      OP_ORI: begin
        w_dec.imm = {16'b0, r_ifid.instr[15:0]};
        w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_OR;
      end
      OP_LUI: begin
        w_dec.imm = {r_ifid.instr[15:0], 16'b0};
        w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_PASS_B;
        w_uses_rs = 1'b0;
      end
      OP_LW:  begin w_dec.alu_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.mem_rd = 1'b1; end
      OP_SW:  begin w_dec.alu_imm = 1'b1; w_dec.mem_wr = 1'b1; w_uses_rt = 1'b1; end
      OP_BEQ: begin w_dec.br_eq = 1'b1; w_uses_rt = 1'b1; end
      OP_BNE: begin w_dec.br_ne = 1'b1; w_uses_rt = 1'b1; end
      OP_J:   begin w_dec.jmp = 1'b1; w_uses_rs = 1'b0; end
      OP_JAL: begin
        w_dec.jmp = 1'b1; w_dec.link = 1'b1; w_dec.reg_wr = 1'b1;
        w_dec.dst = 5'd31; w_uses_rs = 1'b0;
      end
      default: w_uses_rs = 1'b0;
    endcase
  end

  // MEM-stage value: a load in MEM forwards its RAM data, not its address.
  assign w_mem_val = r_exmem.mem_rd ? r_dmem[r_exmem.res[DM_AW+1:2]] : r_exmem.res;

`ifdef FORWARD_EN
  assign w_stall = r_idex.mem_rd &&
                   (raw_hit(r_idex.reg_wr, r_idex.dst, w_rs, w_uses_rs) ||
                    raw_hit(r_idex.reg_wr, r_idex.dst, w_rt, w_uses_rt));

  always_comb begin
    w_op_a = r_idex.a;
    w_op_b = r_idex.b;
    if (raw_hit(r_exmem.reg_wr, r_exmem.dst, r_idex.rs, 1'b1))      w_op_a = w_mem_val;
    else if (raw_hit(r_memwb.reg_wr, r_memwb.dst, r_idex.rs, 1'b1)) w_op_a = r_memwb.wdata;
    if (raw_hit(r_exmem.reg_wr, r_exmem.dst, r_idex.rt, 1'b1))      w_op_b = w_mem_val;
    else if (raw_hit(r_memwb.reg_wr, r_memwb.dst, r_idex.rt, 1'b1)) w_op_b = r_memwb.wdata;
  end
`else
  // Producer in WB is covered by the register-file bypass.
  assign w_stall = raw_hit(r_idex.reg_wr,  r_idex.dst,  w_rs, w_uses_rs) ||
                   raw_hit(r_idex.reg_wr,  r_idex.dst,  w_rt, w_uses_rt) ||
                   raw_hit(r_exmem.reg_wr, r_exmem.dst, w_rs, w_uses_rs) ||
                   raw_hit(r_exmem.reg_wr, r_exmem.dst, w_rt, w_uses_rt);
  assign w_op_a  = r_idex.a;
  assign w_op_b  = r_idex.b;
`endif

  assign w_alu_b  = r_idex.alu_imm ? r_idex.imm : w_op_b;
  assign w_ex_res = r_idex.link ? r_idex.pc4
                                : alu_f(r_idex.alu_op, w_op_a, w_alu_b, r_idex.shamt);

  always_comb begin
    w_taken  = 1'b0;
    w_target = r_idex.pc4 + {r_idex.imm[29:0], 2'b00};
    if (r_idex.jmp_reg) begin
      w_taken  = 1'b1;
      w_target = w_op_a;
    end else if (r_idex.jmp) begin
      w_taken  = 1'b1;
      w_target = {r_idex.pc4[31:28], r_idex.jidx, 2'b00};
    end else if ((r_idex.br_eq && (w_op_a == w_op_b)) || (r_idex.br_ne && (w_op_a != w_op_b))) begin
      w_taken  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc    <= RESET_PC;
      r_ifid  <= '{pc4: '0, instr: NOP};
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_exmem <= '{res: w_ex_res, st_data: w_op_b, dst: r_idex.dst,
                   reg_wr: r_idex.reg_wr, mem_rd: r_idex.mem_rd, mem_wr: r_idex.mem_wr};
      r_memwb <= '{wdata: w_mem_val, dst: r_exmem.dst, reg_wr: r_exmem.reg_wr};
      if (w_taken) begin
        // Redirect wins over a stall: the stalled instruction is younger and is squashed.
        r_pc   <= w_target;
        r_ifid <= '{pc4: '0, instr: NOP};
        r_idex <= '0;
      end else if (w_stall) begin
        r_idex <= '0;
      end else begin
        r_pc   <= r_pc + 32'd4;
        r_ifid <= '{pc4: r_pc + 32'd4, instr: w_instr};
        r_idex <= w_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DM_DEPTH; i++) r_dmem[i] <= '0;
    end else if (r_exmem.mem_wr) begin
      r_dmem[r_exmem.res[DM_AW+1:2]] <= r_exmem.st_data;
    end
  end

endmodule

// File: tb/tb_pipe_comp.sv
module tb_pipe_comp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  always #10 clk = ~clk;

  pipe_comp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  localparam int NPROG = 34;
  localparam logic [31:0] PROG [NPROG] = '{
    32'h20010005, // 0  addi $1,$0,5
    32'h20220003, // 1  addi $2,$1,3
    32'h00411822, // 2  sub  $3,$2,$1
    32'hAC020000, // 3  sw   $2,0($0)
    32'h8C040000, // 4  lw   $4,0($0)
    32'h00842820, // 5  add  $5,$4,$4
    32'h10000002, // 6  beq  $0,$0,+2
    32'h20060001, // 7  addi $6,$0,1   (skipped)
    32'h20060002, // 8  addi $6,$0,2   (skipped)
    32'h200A0001, // 9  addi $10,$0,1
    32'h14210001, // 10 bne  $1,$1,+1  (not taken)
    32'h20070007, // 11 addi $7,$0,7
    32'h0C000010, // 12 jal  16
    32'h08000014, // 13 j    20
    32'h20090063, // 14 addi $9,$0,99  (skipped)
    32'h00000000, // 15 nop
    32'h200B000B, // 16 addi $11,$0,11
    32'h03E00008, // 17 jr   $31
    32'h200C0001, // 18 addi $12,$0,1  (skipped)
    32'h00000000, // 19 nop
    32'h20000009, // 20 addi $0,$0,9
    32'h3C081234, // 21 lui  $8,0x1234
    32'h35085678, // 22 ori  $8,$8,0x5678
    32'h0022682A, // 23 slt  $13,$1,$2
    32'h00017100, // 24 sll  $14,$1,4
    32'h00087C02, // 25 srl  $15,$8,16
    32'h01028024, // 26 and  $16,$8,$2
    32'h00228825, // 27 or   $17,$1,$2
    32'h2832FFFF, // 28 slti $18,$1,-1
    32'h3113FFFF, // 29 andi $19,$8,0xFFFF
    32'h3C148000, // 30 lui  $20,0x8000
    32'h2295FFFF, // 31 addi $21,$20,-1
    32'hFC000000, // 32 unknown opcode
    32'h08000021  // 33 j 33 (spin)
  };

  localparam int NEXP = 23;
  localparam logic [4:0] EXP_SEL [NEXP] = '{
    5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
    5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd31
  };
  localparam logic [31:0] EXP_VAL [NEXP] = '{
    32'd0, 32'd5, 32'd8, 32'd3, 32'd8, 32'd16, 32'd0, 32'd7, 32'h12345678, 32'd0,
    32'd1, 32'd11, 32'd0, 32'd1, 32'd80, 32'h1234, 32'd8, 32'd13, 32'd0, 32'h5678,
    32'h80000000, 32'h7FFFFFFF, 32'd52
  };

  // Registers timed for first appearance: $1=5, $4=8 (lw), $5=16 (add), $10=1 (branch target)
  localparam int NW = 4;
  localparam logic [4:0]  W_SEL [NW] = '{5'd1, 5'd4, 5'd5, 5'd10};
  localparam logic [31:0] W_VAL [NW] = '{32'd5, 32'd8, 32'd16, 32'd1};
`ifdef FORWARD_EN
  localparam int LOAD_USE_GAP = 2;
`else
  localparam int LOAD_USE_GAP = 3;
`endif

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int first_seen [NW];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = (i < NPROG) ? PROG[i] : 32'h0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < NEXP; i++) sb_q.push_back('{sel: EXP_SEL[i], val: EXP_VAL[i]});
  endtask

  task automatic drain_sb(input string pfx);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      reg_sel = e.sel;
      #1;
      chk_eq($sformatf("%s_r%0d", pfx, e.sel), reg_data, e.val);
    end
  endtask

  // Release reset on a negedge, then run ncyc cycles sampling watched regs after each negedge.
  task automatic run_watch(input int ncyc);
    for (int w = 0; w < NW; w++) first_seen[w] = -1;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int w = 0; w < NW; w++) begin
        reg_sel = W_SEL[w];
        #1;
        if (first_seen[w] < 0 && reg_data === W_VAL[w]) first_seen[w] = c;
      end
    end
  endtask

  task automatic check_timing(input string pfx);
    chk_eq({pfx, "_first_wb_cycle"}, 32'(first_seen[0]), 32'd5);
    chk_eq({pfx, "_load_use_gap"}, 32'(first_seen[2] - first_seen[1]), 32'(LOAD_USE_GAP));
    chk_eq({pfx, "_branch_gap"}, 32'(first_seen[3] - first_seen[2]), 32'd4);
  endtask

  initial begin
    load_prog();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reg_sel = 5'd1;  #1; chk_eq("reset_r1", reg_data, 32'd0);
    reg_sel = 5'd31; #1; chk_eq("reset_r31", reg_data, 32'd0);

    push_expected();
    run_watch(150);
    check_timing("run1");
    drain_sb("run1");

    // Restart, interrupt mid-program with an asynchronous reset.
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      reg_sel = 5'(r);
      #1;
      chk_eq($sformatf("midreset_r%0d", r), reg_data, 32'd0);
    end

    push_expected();
    run_watch(150);
    check_timing("run2");
    drain_sb("run2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
